mm_tile_sched: RTL and testbench

- Instruction-level sequencer in front of the matrix-multiply engine (the mm_main datapath).
- Accepts one MM instruction at a time and splits node count N into tiles of at most MAX_TILE_NODES nodes.
- Drives the engine's configuration and start pulse per tile, then waits for the engine's done pulse.
- Reports completion upstream. Weight and bias addresses are reused per tile; input and output addresses advance per tile.

---
 rtl/mm_pkg.sv | 40 ++++
 rtl/mm_tile_addr_gen.sv | 87 ++++++++
 rtl/mm_tile_sched.sv | 205 ++++++++++++++++++++
 tb/tb_mm_tile_sched.sv | 378 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mm_pkg.sv
// mm_pkg: shared types and widths for the matrix-multiply tile scheduler.
//   sched_state_e : scheduler FSM states
//   mm_cfg_t      : per-tile engine configuration bundle
//   tile_len()    : nodes in the current tile, min(rem, max_nodes)
package mm_pkg;

    localparam int unsigned W_WADDR  = 13;  // weight buffer address
    localparam int unsigned W_IOADDR = 11;  // input/output buffer address
    localparam int unsigned W_BADDR  = 9;   // bias buffer address
    localparam int unsigned W_CF     = 8;   // addresses per feature (ci/co)
    localparam int unsigned W_N      = 16;  // node counts
    localparam int unsigned W_FLAGS  = 3;   // {relu, accumulate, bias}

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_NEXT,
        S_DONE
    } sched_state_e;

    typedef struct packed {
        logic [W_WADDR-1:0]  w_addr;
        logic [W_IOADDR-1:0] in_addr;
        logic [W_IOADDR-1:0] out_addr;
        logic [W_BADDR-1:0]  bias_addr;
        logic [W_CF-1:0]     ci;
        logic [W_CF-1:0]     co;
        logic [W_N-1:0]      n;
        logic                r;
        logic                a;
        logic                b;
    } mm_cfg_t;

    function automatic logic [W_N-1:0] tile_len(input logic [W_N-1:0] rem,
                                                 input logic [W_N-1:0] max_nodes);
        return (rem > max_nodes) ? max_nodes : rem;
    endfunction

endpackage

// File: rtl/mm_tile_addr_gen.sv
// mm_tile_addr_gen: remaining-node counter and per-tile input/output address
// advance for mm_tile_sched.
//   load_i       : capture a new instruction (n, strides, start addresses)
//   tile_done_i  : engine finished the current tile, rem -= tile_n
//   advance_i    : step input/output addresses by one tile stride
//   tile_n_o     : nodes in the current tile
//   last_tile_o  : current tile is the final one of the instruction
//   in_addr_o / out_addr_o : current tile start addresses
module mm_tile_addr_gen
    import mm_pkg::*;
#(
    parameter int unsigned MAX_TILE_NODES = 64,
    parameter int unsigned AW_IN          = 11
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             load_i,
    input  logic [W_N-1:0]   n_i,
    input  logic [W_CF-1:0]  ci_i,
    input  logic [W_CF-1:0]  co_i,
    input  logic [AW_IN-1:0] in_addr_i,
    input  logic [AW_IN-1:0] out_addr_i,
    input  logic             tile_done_i,
    input  logic             advance_i,
    output logic [W_N-1:0]   tile_n_o,
    output logic             last_tile_o,
    output logic [AW_IN-1:0] in_addr_o,
    output logic [AW_IN-1:0] out_addr_o
);

    localparam int unsigned    TILE_SHIFT = $clog2(MAX_TILE_NODES);
    localparam logic [W_N-1:0] TILE_MAX   = W_N'(MAX_TILE_NODES);

    logic [W_N-1:0]   rem_q,  rem_d;
    logic [AW_IN-1:0] sin_q,  sin_d;
    logic [AW_IN-1:0] sout_q, sout_d;
    logic [AW_IN-1:0] in_q,   in_d;
    logic [AW_IN-1:0] out_q,  out_d;

    always_comb begin
        rem_d  = rem_q;
        sin_d  = sin_q;
        sout_d = sout_q;
        in_d   = in_q;
        out_d  = out_q;
        if (load_i) begin
            rem_d  = n_i;
            // Tile stride is MAX_TILE_NODES features deep; wraps in the buffer.
            sin_d  = AW_IN'(32'(ci_i) << TILE_SHIFT);
            sout_d = AW_IN'(32'(co_i) << TILE_SHIFT);
            in_d   = in_addr_i;
            out_d  = out_addr_i;
        end else begin
            if (tile_done_i) begin
                rem_d = rem_q - tile_n_o;
            end
            if (advance_i) begin
                in_d  = in_q + sin_q;
                out_d = out_q + sout_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            rem_q  <= '0;
            sin_q  <= '0;
            sout_q <= '0;
            in_q   <= '0;
            out_q  <= '0;
        end else begin
            rem_q  <= rem_d;
            sin_q  <= sin_d;
            sout_q <= sout_d;
            in_q   <= in_d;
            out_q  <= out_d;
        end
    end

    assign tile_n_o    = tile_len(rem_q, TILE_MAX);
    // rem never exceeds the tile size on the final tile, so this predicts
    // "rem reaches zero after this tile" without waiting for the subtract.
    assign last_tile_o = (rem_q <= TILE_MAX);
    assign in_addr_o   = in_q;
    assign out_addr_o  = out_q;

endmodule

// File: rtl/mm_tile_sched.sv
// mm_tile_sched: instruction sequencer in front of the matrix-multiply engine.
// Splits an instruction's node count into tiles of at most MAX_TILE_NODES,
// pulses mm_start_valid per tile with stable config, waits for mm_done, and
// reports inst_done (with inst_err for degenerate instructions).
//   inst_*  : instruction handshake and fields (captured on inst_valid&inst_ready)
//   mm_*    : per-tile engine config, start pulse, done pulse
//   busy    : scheduler not idle
// Optional build macro MM_TILE_SCHED_PERF_EN adds perf_busy_cycles and
// perf_tiles saturating counters, cleared on reset and instruction accept.
module mm_tile_sched
    import mm_pkg::*;
#(
    parameter int unsigned MAX_TILE_NODES = 64,
    parameter int unsigned AW_IN          = 11,
    parameter int unsigned AW_W           = 13
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               inst_valid,
    output logic               inst_ready,
    input  logic [AW_W-1:0]    inst_w_addr,
    input  logic [AW_IN-1:0]   inst_in_addr,
    input  logic [AW_IN-1:0]   inst_out_addr,
    input  logic [8:0]         inst_bias_addr,
    input  logic [7:0]         inst_ci,
    input  logic [7:0]         inst_co,
    input  logic [15:0]        inst_n,
    input  logic [2:0]         inst_flags,
    output logic               mm_start_valid,
    output logic [AW_W-1:0]    mm_weight_start_addr,
    output logic [AW_IN-1:0]   mm_input_start_addr,
    output logic [AW_IN-1:0]   mm_output_start_addr,
    output logic [8:0]         mm_bias_start_addr,
    output logic [7:0]         mm_ci,
    output logic [7:0]         mm_co,
    output logic [15:0]        mm_n,
    output logic               mm_r,
    output logic               mm_a,
    output logic               mm_b,
    input  logic               mm_done,
    output logic               busy,
    output logic               inst_done,
    output logic               inst_err
`ifdef MM_TILE_SCHED_PERF_EN
    ,
    output logic [31:0]        perf_busy_cycles,
    output logic [15:0]        perf_tiles
`endif
);

    sched_state_e state_q, state_d;

    logic [AW_W-1:0]    w_q;
    logic [8:0]         bias_q;
    logic [7:0]         ci_q;
    logic [7:0]         co_q;
    logic [2:0]         flags_q;
    logic               err_q;

    logic               accept;
    logic               degenerate;
    logic               start;
    logic               done;
    logic               tile_done;
    logic               advance;
    logic [W_N-1:0]     tile_n;
    logic               last_tile;
    logic [AW_IN-1:0]   in_addr;
    logic [AW_IN-1:0]   out_addr;
    mm_cfg_t            cfg;

    assign inst_ready = rstn && (state_q == S_IDLE);
    assign accept     = inst_valid && inst_ready;
    assign degenerate = (inst_n == '0) || (inst_ci == '0) || (inst_co == '0);

    always_comb begin
        state_d   = state_q;
        start     = 1'b0;
        done      = 1'b0;
        tile_done = 1'b0;
        advance   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = degenerate ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE: begin
                start   = 1'b1;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (mm_done) begin
                    tile_done = 1'b1;
                    state_d   = last_tile ? S_DONE : S_NEXT;
                end
            end
            S_NEXT: begin
                advance = 1'b1;
                state_d = S_ISSUE;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            w_q     <= '0;
            bias_q  <= '0;
            ci_q    <= '0;
            co_q    <= '0;
            flags_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                w_q     <= inst_w_addr;
                bias_q  <= inst_bias_addr;
                ci_q    <= inst_ci;
                co_q    <= inst_co;
                flags_q <= inst_flags;
                err_q   <= degenerate;
            end
        end
    end

    mm_tile_addr_gen #(
        .MAX_TILE_NODES (MAX_TILE_NODES),
        .AW_IN          (AW_IN)
    ) u_addr_gen (
        .clk         (clk),
        .rstn        (rstn),
        .load_i      (accept),
        .n_i         (inst_n),
        .ci_i        (inst_ci),
        .co_i        (inst_co),
        .in_addr_i   (inst_in_addr),
        .out_addr_i  (inst_out_addr),
        .tile_done_i (tile_done),
        .advance_i   (advance),
        .tile_n_o    (tile_n),
        .last_tile_o (last_tile),
        .in_addr_o   (in_addr),
        .out_addr_o  (out_addr)
    );

    // Config comes straight from registers that only change on accept, on
    // leaving WAIT, or in NEXT, so it is stable from ISSUE through WAIT.
    always_comb begin
        cfg.w_addr    = W_WADDR'(w_q);
        cfg.in_addr   = W_IOADDR'(in_addr);
        cfg.out_addr  = W_IOADDR'(out_addr);
        cfg.bias_addr = bias_q;
        cfg.ci        = ci_q;
        cfg.co        = co_q;
        cfg.n         = tile_n;
        cfg.r         = flags_q[2];
        cfg.a         = flags_q[1];
        cfg.b         = flags_q[0];
    end

    assign mm_start_valid       = start;
    assign mm_weight_start_addr = AW_W'(cfg.w_addr);
    assign mm_input_start_addr  = AW_IN'(cfg.in_addr);
    assign mm_output_start_addr = AW_IN'(cfg.out_addr);
    assign mm_bias_start_addr   = cfg.bias_addr;
    assign mm_ci                = cfg.ci;
    assign mm_co                = cfg.co;
    assign mm_n                 = cfg.n;
    assign mm_r                 = cfg.r;
    assign mm_a                 = cfg.a;
    assign mm_b                 = cfg.b;

    assign busy      = (state_q != S_IDLE);
    assign inst_done = done;
    assign inst_err  = done && err_q;

`ifdef MM_TILE_SCHED_PERF_EN
    logic [31:0] busy_cnt_q;
    logic [15:0] tiles_cnt_q;

    always_ff @(posedge clk) begin
        if (!rstn || accept) begin
            busy_cnt_q  <= '0;
            tiles_cnt_q <= '0;
        end else begin
            if (busy && (busy_cnt_q != '1)) begin
                busy_cnt_q <= busy_cnt_q + 32'd1;
            end
            if (start && (tiles_cnt_q != '1)) begin
                tiles_cnt_q <= tiles_cnt_q + 16'd1;
            end
        end
    end

    assign perf_busy_cycles = busy_cnt_q;
    assign perf_tiles       = tiles_cnt_q;
`endif

endmodule

// File: tb/tb_mm_tile_sched.sv
// tb_mm_tile_sched: scoreboard bench for mm_tile_sched. Expected tiles and
// completions are queued at instruction accept; a monitor pops and compares
// on mm_start_valid / inst_done. A behavioural engine answers each start
// with mm_done after a random latency.
module tb_mm_tile_sched;

    localparam int MAXT = 64;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        inst_valid = 1'b0;
    logic        inst_ready;
    logic [12:0] inst_w_addr = '0;
    logic [10:0] inst_in_addr = '0;
    logic [10:0] inst_out_addr = '0;
    logic [8:0]  inst_bias_addr = '0;
    logic [7:0]  inst_ci = '0;
    logic [7:0]  inst_co = '0;
    logic [15:0] inst_n = '0;
    logic [2:0]  inst_flags = '0;
    logic        mm_start_valid;
    logic [12:0] mm_weight_start_addr;
    logic [10:0] mm_input_start_addr;
    logic [10:0] mm_output_start_addr;
    logic [8:0]  mm_bias_start_addr;
    logic [7:0]  mm_ci;
    logic [7:0]  mm_co;
    logic [15:0] mm_n;
    logic        mm_r, mm_a, mm_b;
    logic        mm_done;
    logic        busy;
    logic        inst_done;
    logic        inst_err;
`ifdef MM_TILE_SCHED_PERF_EN
    logic [31:0] perf_busy_cycles;
    logic [15:0] perf_tiles;
`endif

    logic eng_done = 1'b0;
    logic extra_done = 1'b0;
    assign mm_done = eng_done | extra_done;

    mm_tile_sched #(
        .MAX_TILE_NODES (MAXT),
        .AW_IN          (11),
        .AW_W           (13)
    ) dut (
        .clk                  (clk),
        .rstn                 (rstn),
        .inst_valid           (inst_valid),
        .inst_ready           (inst_ready),
        .inst_w_addr          (inst_w_addr),
        .inst_in_addr         (inst_in_addr),
        .inst_out_addr        (inst_out_addr),
        .inst_bias_addr       (inst_bias_addr),
        .inst_ci              (inst_ci),
        .inst_co              (inst_co),
        .inst_n               (inst_n),
        .inst_flags           (inst_flags),
        .mm_start_valid       (mm_start_valid),
        .mm_weight_start_addr (mm_weight_start_addr),
        .mm_input_start_addr  (mm_input_start_addr),
        .mm_output_start_addr (mm_output_start_addr),
        .mm_bias_start_addr   (mm_bias_start_addr),
        .mm_ci                (mm_ci),
        .mm_co                (mm_co),
        .mm_n                 (mm_n),
        .mm_r                 (mm_r),
        .mm_a                 (mm_a),
        .mm_b                 (mm_b),
        .mm_done              (mm_done),
        .busy                 (busy),
        .inst_done            (inst_done),
        .inst_err             (inst_err)
`ifdef MM_TILE_SCHED_PERF_EN
        ,
        .perf_busy_cycles     (perf_busy_cycles),
        .perf_tiles           (perf_tiles)
`endif
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        int w, in_a, out_a, bias, ci, co, n, flags;
        bit first;
        int exp_cyc;
    } tile_t;

    typedef struct {
        bit err;
        bit degen;
        int acc_cyc;
    } done_t;

    tile_t tile_q[$];
    done_t done_q[$];

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int n_starts = 0;
    int stall_idx = -1;
    int eng_last_done = -100;
    int last_inst_done = -100;
    bit spur_en = 1'b0;

    task automatic check(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        tests++;
        fails++;
        $display("FAIL %s: event not expected here (cycle %0d)", name, cyc);
    endtask

    // Reference: carve n into MAXT-sized tiles, advance in/out by MAXT*ci/co
    // modulo the 2048-entry buffer.
    task automatic model(input int w, input int in_a, input int out_a, input int bias,
                         input int ci, input int co, input int n, input int flags,
                         input int acc);
        int rem, ia, oa;
        bit degen;
        tile_t t;
        done_t d;
        degen = (n == 0) || (ci == 0) || (co == 0);
        rem = n; ia = in_a; oa = out_a;
        t.first = 1'b1;
        if (!degen) begin
            while (rem > 0) begin
                t.w = w; t.in_a = ia; t.out_a = oa; t.bias = bias;
                t.ci = ci; t.co = co; t.flags = flags;
                t.n = (rem > MAXT) ? MAXT : rem;
                t.exp_cyc = acc + 1;
                tile_q.push_back(t);
                t.first = 1'b0;
                rem = rem - t.n;
                ia = (ia + MAXT * ci) % 2048;
                oa = (oa + MAXT * co) % 2048;
            end
        end
        d.err = degen; d.degen = degen; d.acc_cyc = acc;
        done_q.push_back(d);
    endtask

    initial forever @(posedge clk) cyc++;

    // Monitor
    initial forever begin
        @(posedge clk);
        #1;
        if (rstn) begin
            if (mm_start_valid) begin
                n_starts++;
                if (tile_q.size() == 0) begin
                    fail_now("unexpected_start");
                end else begin
                    tile_t t;
                    t = tile_q.pop_front();
                    check("tile_n", mm_n, t.n);
                    check("tile_in_addr", mm_input_start_addr, t.in_a);
                    check("tile_out_addr", mm_output_start_addr, t.out_a);
                    check("tile_w_addr", mm_weight_start_addr, t.w);
                    check("tile_bias_addr", mm_bias_start_addr, t.bias);
                    check("tile_ci_co", {mm_ci, mm_co}, (t.ci << 8) | t.co);
                    check("tile_flags", {mm_r, mm_a, mm_b}, t.flags);
                    if (t.first) check("first_start_cycle", cyc, t.exp_cyc);
                    else         check("next_start_cycle", cyc, eng_last_done + 2);
                end
            end
            if (inst_done) begin
                if (done_q.size() == 0) begin
                    fail_now("unexpected_inst_done");
                end else begin
                    done_t d;
                    d = done_q.pop_front();
                    check("inst_err", inst_err, d.err);
                    check("tiles_left_at_done", tile_q.size(), 0);
                    if (d.degen) check("done_cycle_degen", cyc, d.acc_cyc + 1);
                    else         check("done_cycle", cyc, eng_last_done + 1);
                end
                last_inst_done = cyc;
            end else if (inst_err) begin
                fail_now("inst_err_without_done");
            end
        end
    end

    // Behavioural engine
    initial begin : engine
        bit pend;
        int cnt;
        logic [78:0] cap, cur;
        pend = 1'b0; cnt = 0; cap = '0;
        forever begin
            @(negedge clk);
            eng_done = 1'b0;
            cur = {mm_weight_start_addr, mm_input_start_addr, mm_output_start_addr,
                   mm_bias_start_addr, mm_ci, mm_co, mm_n, mm_r, mm_a, mm_b};
            if (!rstn) begin
                pend = 1'b0;
            end else begin
                if (pend) begin
                    if (cnt == 0) begin
                        eng_done = 1'b1;
                        pend = 1'b0;
                        eng_last_done = cyc;
                        tests++;
                        if (cur != cap) begin
                            fails++;
                            $display("FAIL cfg_stable: got %h expected %h", cur, cap);
                        end
                    end else begin
                        cnt--;
                    end
                end
                if (mm_start_valid) begin
                    cap = cur;
                    cnt = $urandom_range(0, 4);
                    pend = (n_starts != stall_idx);
                    // A done in the ISSUE cycle must be ignored.
                    if (spur_en && ($urandom_range(0, 3) == 0)) eng_done = 1'b1;
                end
            end
        end
    end

    task automatic send(input int w, input int in_a, input int out_a, input int bias,
                        input int ci, input int co, input int n, input int flags,
                        input bit keep, input bit bp_check);
        bit ok;
        ok = 1'b0;
        @(negedge clk);
        inst_w_addr = 13'(w); inst_in_addr = 11'(in_a); inst_out_addr = 11'(out_a);
        inst_bias_addr = 9'(bias); inst_ci = 8'(ci); inst_co = 8'(co);
        inst_n = 16'(n); inst_flags = 3'(flags);
        inst_valid = 1'b1;
        for (int k = 0; k < 3000; k++) begin
            if (inst_ready) begin
                ok = 1'b1;
                model(w, in_a, out_a, bias, ci, co, n, flags, cyc);
                if (bp_check) check("bp_accept_cycle", cyc, last_inst_done + 1);
                @(posedge clk);
                break;
            end
            @(negedge clk);
        end
        if (!ok) fail_now("accept_timeout");
        if (!keep) begin
            @(negedge clk);
            inst_valid = 1'b0;
        end
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 5000; k++) begin
            @(negedge clk);
            if (done_q.size() == 0 && tile_q.size() == 0 && !busy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            fail_now("job_timeout");
            tile_q.delete();
            done_q.delete();
        end
    endtask

    task automatic check_outputs_zero(input string name);
        logic [127:0] v;
        v = '0;
        v[85:0] = {mm_start_valid, mm_weight_start_addr, mm_input_start_addr,
                   mm_output_start_addr, mm_bias_start_addr, mm_ci, mm_co, mm_n,
                   mm_r, mm_a, mm_b, busy, inst_done, inst_err};
        check(name, $countones(v), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1);
    end

    initial begin
        int n, ci, co;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset_outputs");
        rstn = 1'b1;
        @(negedge clk);
        check("ready_after_reset", inst_ready, 1);
        check("busy_after_reset", busy, 0);

        // mm_done while idle does nothing
        extra_done = 1'b1;
        @(negedge clk);
        extra_done = 1'b0;
        @(negedge clk);
        check("idle_done_busy", busy, 0);
        check("idle_done_ready", inst_ready, 1);

        // Single tile
        send(5, 16, 100, 7, 4, 2, 10, 3'b011, 1'b0, 1'b0);
        wait_idle();
`ifdef MM_TILE_SCHED_PERF_EN
        check("perf_tiles_single", perf_tiles, 1);
`endif

        // Multi-tile, with spurious done in ISSUE enabled
        spur_en = 1'b1;
        send(5, 16, 100, 7, 4, 2, 150, 3'b100, 1'b0, 1'b0);
        wait_idle();
`ifdef MM_TILE_SCHED_PERF_EN
        check("perf_tiles_multi", perf_tiles, 3);
`endif

        // Input address wrap
        send(300, 2000, 40, 11, 16, 2, 130, 3'b001, 1'b0, 1'b0);
        wait_idle();

        // Degenerate instructions
        send(1, 2, 3, 4, 4, 2, 0, 3'b111, 1'b0, 1'b0);
        wait_idle();
        send(1, 2, 3, 4, 0, 2, 50, 3'b000, 1'b0, 1'b0);
        wait_idle();
        send(1, 2, 3, 4, 4, 0, 50, 3'b010, 1'b0, 1'b0);
        wait_idle();

        // Reset during WAIT of tile 2
        stall_idx = n_starts + 2;
        send(9, 64, 128, 3, 2, 3, 200, 3'b101, 1'b0, 1'b0);
        for (int k = 0; k < 500 && n_starts < stall_idx; k++) @(negedge clk);
        check("reached_tile2", n_starts, stall_idx);
        repeat (3) @(negedge clk);
        check("busy_in_wait", busy, 1);
        rstn = 1'b0;
        tile_q.delete();
        done_q.delete();
        @(negedge clk);
        check_outputs_zero("midreset_outputs");
        @(negedge clk);
        rstn = 1'b1;
        stall_idx = -1;
        repeat (8) @(negedge clk);
        check("post_reset_busy", busy, 0);
        check("post_reset_ready", inst_ready, 1);
        send(20, 500, 600, 8, 3, 5, 70, 3'b110, 1'b0, 1'b0);
        wait_idle();

        // Back-pressure: inst_valid held through a 2-tile job
        send(2, 10, 20, 1, 1, 1, 100, 3'b011, 1'b1, 1'b0);
        send(3, 30, 40, 2, 2, 2, 5, 3'b000, 1'b0, 1'b1);
        wait_idle();

        // Randomized jobs
        for (int j = 0; j < 30; j++) begin
            n  = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 300);
            ci = ($urandom_range(0, 14) == 0) ? 0 : $urandom_range(1, 255);
            co = ($urandom_range(0, 14) == 0) ? 0 : $urandom_range(1, 255);
            send($urandom_range(0, 8191), $urandom_range(0, 2047), $urandom_range(0, 2047),
                 $urandom_range(0, 511), ci, co, n, $urandom_range(0, 7), 1'b0, 1'b0);
            wait_idle();
        end

        repeat (5) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
